// File: rtl/rt_display_if.sv
// Bus between the reaction-timer controller and the display driver:
// controller-side mode/value/load, display-side busy and the active-low digit lines.
interface rt_display_if;
  logic [1:0]  mode;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [7:0]  AN;
  logic [6:0]  seg;

  modport master (output mode, value, load, input busy, AN, seg);
  modport slave  (input mode, value, load, output busy, AN, seg);
endinterface

// File: rtl/rt_display_driver.sv
// Reaction-timer display stage: iterative double-dabble BCD conversion of the
// millisecond count and an 8-digit multiplexed, active-low seven-segment scanner.
module rt_display_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int SAT_VALUE   = 9999
) (
  input logic       clk,
  input logic       reset,
  rt_display_if.slave dio
);

  localparam int          RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [13:0] SAT14    = 14'(SAT_VALUE);
  localparam logic [6:0]  BLANK    = 7'b1111111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_next;
  logic [13:0] bin_sh;
  logic [15:0] bcd_scr;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_com;
  logic [3:0]  iter;
  logic        last_shift;
  logic [13:0] value_sat;

  logic [RW-1:0] ref_cnt;
  logic [2:0]    idx;
  logic [3:0]    show;
  logic [6:0]    seg_next;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: digit_glyph = 7'b1000000;
      4'd1: digit_glyph = 7'b1111001;
      4'd2: digit_glyph = 7'b0100100;
      4'd3: digit_glyph = 7'b0110000;
      4'd4: digit_glyph = 7'b0011001;
      4'd5: digit_glyph = 7'b0010010;
      4'd6: digit_glyph = 7'b0000010;
      4'd7: digit_glyph = 7'b1111000;
      4'd8: digit_glyph = 7'b0000000;
      4'd9: digit_glyph = 7'b0010000;
      default: digit_glyph = 7'b1111111;
    endcase
  endfunction

  assign value_sat  = (dio.value > SAT14) ? SAT14 : dio.value;
  assign last_shift = (iter == 4'd13);
  assign dio.busy   = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dio.load) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction is applied before every shift, including the first.
  always_comb begin
    bcd_adj = bcd_scr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_scr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_scr[4*i +: 4] + 4'd3;
    end
  end

  // The committed register is written only by the final shift, so it never holds a partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sh  <= '0;
      bcd_scr <= '0;
      iter    <= '0;
      bcd_com <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dio.load) begin
            bin_sh  <= value_sat;
            bcd_scr <= '0;
            iter    <= '0;
          end
        end
        SHIFT: begin
          {bcd_scr, bin_sh} <= {bcd_adj[14:0], bin_sh, 1'b0};
          iter              <= iter + 4'd1;
          if (last_shift) bcd_com <= {bcd_adj[14:0], bin_sh[13]};
        end
        default: ;
      endcase
    end
  end

  assign show[0] = 1'b1;
  assign show[1] = |bcd_com[15:4];
  assign show[2] = |bcd_com[15:8];
  assign show[3] = |bcd_com[15:12];

  always_comb begin
    seg_next = BLANK;
    case (dio.mode)
      2'd1: begin
        case (idx)
          3'd4:    seg_next = 7'b0001000;
          3'd3:    seg_next = 7'b1000111;
          3'd2:    seg_next = 7'b1000000;
          3'd1:    seg_next = 7'b0001001;
          3'd0:    seg_next = 7'b0001000;
          default: seg_next = BLANK;
        endcase
      end
      2'd2: begin
        if (!idx[2] && show[idx[1:0]]) seg_next = digit_glyph(bcd_com[{idx[1:0], 2'b00} +: 4]);
      end
      2'd3: begin
        if (!idx[2]) seg_next = digit_glyph(4'd9);
      end
      default: seg_next = BLANK;
    endcase
  end

  // Outputs are registered, so AN/seg always show the slot and mode seen one edge earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      dio.AN  <= 8'hFF;
      dio.seg <= BLANK;
    end else begin
      dio.AN  <= ~(8'b0000_0001 << idx);
      dio.seg <= seg_next;
      if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rt_display_driver.sv
// Randomized self-checking bench for rt_display_driver; expected digits come
// from decimal arithmetic on the committed number and a cycle-count scan model.
module tb_rt_display_driver;

  localparam int REFRESH_DIV = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edges = 0;
  int   model_num = 0;
  int   cnt;

  rt_display_if dio();

  rt_display_driver #(.REFRESH_DIV(REFRESH_DIV), .SAT_VALUE(9999)) dut (
    .clk   (clk),
    .reset (reset),
    .dio   (dio)
  );

  always #5 clk = ~clk;

  // Count of non-reset clock edges since reset was last released.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic logic [6:0] digit_glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int model_index(input int e);
    return ((e - 1) / REFRESH_DIV) % 8;
  endfunction

  function automatic logic [7:0] exp_an(input int e);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << model_index(e));
  endfunction

  function automatic logic [6:0] exp_seg(input int m, input int num, input int i);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    case (m)
      1: begin
        case (i)
          4, 0: return 7'b0001000;
          3:    return 7'b1000111;
          2:    return 7'b1000000;
          1:    return 7'b0001001;
          default: return 7'b1111111;
        endcase
      end
      2: begin
        if (i > 3) return 7'b1111111;
        if (i > 0 && num < p) return 7'b1111111;
        return digit_glyph((num / p) % 10);
      end
      3: return (i <= 3) ? digit_glyph(9) : 7'b1111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic pulse_load(input int v);
    @(negedge clk);
    dio.value = 14'(v);
    dio.load  = 1'b1;
    @(negedge clk);
    dio.load  = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (dio.busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.AN !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_an: got %h want ff", dio.AN); end
      n_cmp++;
      if (dio.seg !== 7'h7F) begin n_fail++; $display("[TB] FAIL reset_seg: got %h want 7f", dio.seg); end
      n_cmp++;
      if (dio.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", dio.busy); end
    end
    reset = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.AN !== exp_an(edges)) begin n_fail++; $display("[TB] FAIL scan_an: got %h want %h", dio.AN, exp_an(edges)); end
      n_cmp++;
      if (dio.seg !== 7'h7F) begin n_fail++; $display("[TB] FAIL blank_seg: got %h want 7f", dio.seg); end
    end
  endtask

  task automatic test_welcome();
    dio.mode = 2'd1;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.AN !== exp_an(edges)) begin n_fail++; $display("[TB] FAIL welcome_an: got %h want %h", dio.AN, exp_an(edges)); end
      n_cmp++;
      if (dio.seg !== exp_seg(1, 0, model_index(edges)))
        begin n_fail++; $display("[TB] FAIL welcome_seg idx%0d: got %b want %b", model_index(edges), dio.seg, exp_seg(1, 0, model_index(edges))); end
    end
  endtask

  task automatic test_convert();
    dio.mode = 2'd2;
    pulse_load(237);
    model_num = 237;
    wait_idle(cnt);
    n_cmp++;
    if (cnt !== 14) begin n_fail++; $display("[TB] FAIL busy_len_237: got %0d want 14", cnt); end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.seg !== exp_seg(2, model_num, model_index(edges)))
        begin n_fail++; $display("[TB] FAIL num237_seg idx%0d: got %b want %b", model_index(edges), dio.seg, exp_seg(2, model_num, model_index(edges))); end
    end
  endtask

  task automatic test_saturate_and_zero();
    int vals[2];
    vals[0] = 12000;
    vals[1] = 0;
    for (int t = 0; t < 2; t++) begin
      pulse_load(vals[t]);
      model_num = (vals[t] > 9999) ? 9999 : vals[t];
      wait_idle(cnt);
      n_cmp++;
      if (cnt !== 14) begin n_fail++; $display("[TB] FAIL busy_len_%0d: got %0d want 14", vals[t], cnt); end
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        n_cmp++;
        if (dio.seg !== exp_seg(2, model_num, model_index(edges)))
          begin n_fail++; $display("[TB] FAIL bound_%0d_seg idx%0d: got %b want %b", vals[t], model_index(edges), dio.seg, exp_seg(2, model_num, model_index(edges))); end
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_load(1234);
    model_num = 1234;
    cnt = 0;
    repeat (5) begin cnt++; @(negedge clk); end
    dio.value = 14'd42;
    dio.load  = 1'b1;
    cnt++;
    @(negedge clk);
    dio.load  = 1'b0;
    begin
      int rest;
      wait_idle(rest);
      cnt = cnt + rest;
    end
    n_cmp++;
    if (cnt !== 14) begin n_fail++; $display("[TB] FAIL busy_len_ignored: got %0d want 14", cnt); end
    @(negedge clk);
    n_cmp++;
    if (dio.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignored_restart: busy got %b want 0", dio.busy); end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.seg !== exp_seg(2, model_num, model_index(edges)))
        begin n_fail++; $display("[TB] FAIL ignored_seg idx%0d: got %b want %b", model_index(edges), dio.seg, exp_seg(2, model_num, model_index(edges))); end
    end
  endtask

  task automatic test_early_mode();
    for (int m = 3; m >= 2; m--) begin
      dio.mode = 2'(m);
      @(negedge clk);
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        n_cmp++;
        if (dio.AN !== exp_an(edges)) begin n_fail++; $display("[TB] FAIL mode%0d_an: got %h want %h", m, dio.AN, exp_an(edges)); end
        n_cmp++;
        if (dio.seg !== exp_seg(m, model_num, model_index(edges)))
          begin n_fail++; $display("[TB] FAIL mode%0d_seg idx%0d: got %b want %b", m, model_index(edges), dio.seg, exp_seg(m, model_num, model_index(edges))); end
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    dio.mode = 2'd2;
    pulse_load(5678);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dio.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b want 0", dio.busy); end
    n_cmp++;
    if (dio.AN !== 8'hFF) begin n_fail++; $display("[TB] FAIL abort_an: got %h want ff", dio.AN); end
    reset = 1'b0;
    model_num = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dio.AN !== exp_an(edges)) begin n_fail++; $display("[TB] FAIL abort_scan_an: got %h want %h", dio.AN, exp_an(edges)); end
      n_cmp++;
      if (dio.seg !== exp_seg(2, model_num, model_index(edges)))
        begin n_fail++; $display("[TB] FAIL abort_seg idx%0d: got %b want %b", model_index(edges), dio.seg, exp_seg(2, model_num, model_index(edges))); end
    end
  endtask

  task automatic test_random();
    int v;
    dio.mode = 2'd2;
    for (int t = 0; t < 8; t++) begin
      case (t)
        0:       v = 9999;
        1:       v = 10000;
        2:       v = 16383;
        default: v = $urandom_range(0, 16383);
      endcase
      if (t == 3) v = $urandom_range(1, 99);
      pulse_load(v);
      model_num = (v > 9999) ? 9999 : v;
      wait_idle(cnt);
      n_cmp++;
      if (cnt !== 14) begin n_fail++; $display("[TB] FAIL busy_len_rand %0d: got %0d want 14", v, cnt); end
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        n_cmp++;
        if (dio.seg !== exp_seg(2, model_num, model_index(edges)))
          begin n_fail++; $display("[TB] FAIL rand_%0d_seg idx%0d: got %b want %b", v, model_index(edges), dio.seg, exp_seg(2, model_num, model_index(edges))); end
      end
    end
  endtask

  initial begin
    dio.mode  = 2'd0;
    dio.value = 14'd0;
    dio.load  = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_welcome();
    test_convert();
    test_saturate_and_zero();
    test_back_to_back();
    test_early_mode();
    test_reset_mid_conversion();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rt_display_driver.md
Name: rt_display_driver

Overview:
- Output stage of the reaction timer. Consumes the controller's display mode and reaction-time value and drives the 8-digit, active-low, multiplexed seven-segment display (AN/seg).
- Converts the binary millisecond count to BCD with an iterative double-dabble engine, one shift per clock.
- Holds fixed glyph screens: blank, welcome "ALOHA", and early-press "9999".

Parameters:
- REFRESH_DIV, 100_000, clk cycles each digit is shown (1 ms at 100 MHz); benches use 4.
- SAT_VALUE, 9999, clamp applied to value before conversion.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- mode  in  2  0=blank, 1=welcome, 2=number, 3=early
- value  in  14  reaction time in ms, unsigned binary
- load  in  1  single-cycle pulse: latch value and start conversion
- busy  out  1  conversion in progress
- AN  out  8  digit anodes, active-low, one-hot-low
- seg  out  7  {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (synchronous, active-high, has priority over all other inputs):
  - AN=8'hFF, seg=7'h7F, busy=0.
  - Committed BCD register=0000, refresh counter=0, digit index=0.
  - Reset asserted mid-conversion aborts the conversion; the BCD register stays 0000.
- Conversion engine:
  - States: IDLE, SHIFT.
  - IDLE + load=1: latch min(value, SAT_VALUE) into the shift register, clear the scratch BCD, set iteration count=0, go to SHIFT. busy=1 from the next cycle.
  - SHIFT, each cycle:
    - add 3 to any scratch BCD nibble >=5;
    - shift {bcd,bin} left by 1;
    - increment the count.
  - After the 14th shift:
    - copy the scratch BCD into the committed BCD register in that same edge;
    - return to IDLE; busy=0 on the following cycle.
  - Timing: busy is high exactly 14 cycles; the new digits appear on the display at most 15 cycles after load.
  - load while busy=1 is ignored. load in any mode starts a conversion.
  - The committed register never shows partial results.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index increments modulo 8.
  - AN and seg are registered. AN = ~(1<<index), seg = glyph(mode, index), both reflecting index and mode as sampled on the previous cycle.
  - Every digit keeps its anode active for its slot, including blank digits.
  - A mode change affects seg from the next clock; the scan position is not disturbed.
- Glyphs (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, L=1000111, O=1000000, H=0001001, blank=1111111
- Screen content by digit index (index 0 = rightmost):
  - mode 0: all blank.
  - mode 1: idx4..0 = A,L,O,H,A; idx7..5 blank.
  - mode 2: idx3..0 = committed BCD thousands..ones, leading zeros blanked, idx0 always shown; idx7..4 blank.
  - mode 3: idx3..0 = 9,9,9,9; idx7..4 blank. The BCD register is unaffected.
- Boundaries:
  - value > 9999 displays 9999.
  - value=0 displays a single "0".
  - load and reset in the same cycle: reset wins.

Test Plan:
- Reset held 3 cycles, REFRESH_DIV=4 -> AN=FF, seg=7F during reset. First edge after release gives AN=FE. AN steps FE,FD,FB,...,7F,FE every 4 cycles.
- mode=1 -> over one full scan: idx4=0001000, idx3=1000111, idx2=1000000, idx1=0001001, idx0=0001000, idx7..5=1111111.
- mode=2, value=237, load pulse -> busy high exactly 14 cycles. Scan then shows idx2=2, idx1=3, idx0=7, idx3 and idx7..4 blank.
- mode=2, value=12000, load -> display 9,9,9,9. Then value=0, load -> only idx0 = 1000000, others blank.
- Second load issued 5 cycles into a conversion (value 1234 then 42) -> ignored; result 1234. Reset asserted mid-conversion -> busy=0 next cycle, mode 2 shows "0".
- mode 3 after a committed 1234, then back to mode 2 -> shows 9999 while in mode 3, then 1234 again with no new load.
